// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker and its matching generator:
// FSM state encoding, default PRBS5 polynomial and a counter-width helper.
package prbs_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Default 5-bit tap mask shared with the generator: next = ^(shreg & TAPS).
  localparam int unsigned   PRBS5_WIDTH = 5;
  localparam logic [4:0]    PRBS5_TAPS  = 5'b10010;

  // Bits needed to hold the values 0..n (at least one bit).
  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. A clear that coincides with
// an increment leaves the counter at 1 so that event is not lost.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count events, holding at all-ones instead of wrapping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises to a serial PRBS stream, then flywheels the
// local register and counts mismatching bits.
// Optional build macro PRBS_CHECKER_BITCNT_EN adds a 32-bit saturating count of
// bits compared while locked (bit_cnt), cleared together with err_cnt.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned      WIDTH    = PRBS5_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = PRBS5_TAPS,
  parameter int unsigned      LOCK_CNT = 8,
  parameter int unsigned      LOSS_CNT = 4,
  parameter int unsigned      ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
`ifdef PRBS_CHECKER_BITCNT_EN
  ,output logic [31:0]     bit_cnt
`endif
);

  localparam int MATCH_W = cnt_width(LOCK_CNT);
  localparam int MISS_W  = cnt_width(LOSS_CNT);

  state_e             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [MATCH_W-1:0] r_match_cnt;
  logic [MISS_W-1:0]  r_miss_cnt;
  logic               r_err_pulse;

  logic w_pred;
  logic w_mismatch;
  logic w_err_inc;
  logic w_lock_hit;
  logic w_loss_hit;

  // Prediction of the incoming bit from the local register.
  assign w_pred     = ^(r_shreg & TAPS);
  assign w_mismatch = (in_bit != w_pred);
  // A mismatch only counts as an error once locked.
  assign w_err_inc  = in_valid && (r_state == LOCKED) && w_mismatch;
  // This match/miss is the one that reaches the threshold.
  assign w_lock_hit = (r_match_cnt == MATCH_W'(LOCK_CNT - 1));
  assign w_loss_hit = (r_miss_cnt  == MISS_W'(LOSS_CNT - 1));

  // Search/lock state machine with shift register and match/miss run counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_shreg     <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else if (in_valid) begin
      if (r_state == SEARCH) begin
        // Load the received bit; an all-zero register never counts as a match.
        r_shreg <= {r_shreg[WIDTH-2:0], in_bit};
        if (!w_mismatch && (r_shreg != '0)) begin
          if (w_lock_hit) begin
            r_state     <= LOCKED;
            r_match_cnt <= '0;
          end else begin
            r_match_cnt <= r_match_cnt + 1'b1;
          end
        end else begin
          r_match_cnt <= '0;
        end
      end else begin
        // Flywheel: a channel error is not fed back, so it costs one error only.
        r_shreg <= {r_shreg[WIDTH-2:0], w_pred};
        if (w_mismatch) begin
          if (w_loss_hit) begin
            r_state     <= SEARCH;
            r_miss_cnt  <= '0;
            r_match_cnt <= '0;
          end else begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
          end
        end else begin
          r_miss_cnt <= '0;
        end
      end
    end
  end

  // One-cycle error strobe, low on every invalid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= w_err_inc;
    end
  end

  assign locked    = (r_state == LOCKED);
  assign err_pulse = r_err_pulse;

  sat_counter #(
    .W (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_err_inc),
    .clr   (err_clr),
    .count (err_cnt)
  );

`ifdef PRBS_CHECKER_BITCNT_EN
  logic w_bit_inc;
  assign w_bit_inc = in_valid && (r_state == LOCKED);

  sat_counter #(
    .W (32)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_bit_inc),
    .clr   (err_clr),
    .count (bit_cnt)
  );
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker. Two instances share one stimulus
// stream: dut_a with LOSS_CNT=4 and dut_b with LOSS_CNT=300. A bit-history
// reference model predicts locked/err_pulse/err_cnt for each every cycle.
module tb_prbs_checker;

  localparam logic [4:0] TB_TAPS  = 5'b10010;
  localparam int         TB_LOCK  = 8;
  localparam int         ERR_MAX  = 255;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_bit;
  logic       err_clr;
  logic       locked_a, err_pulse_a;
  logic [7:0] err_cnt_a;
  logic       locked_b, err_pulse_b;
  logic [7:0] err_cnt_b;

  int n_vec  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  prbs_checker #(
    .WIDTH(5), .TAPS(5'b10010), .LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .err_clr(err_clr), .locked(locked_a), .err_pulse(err_pulse_a),
    .err_cnt(err_cnt_a)
  );

  prbs_checker #(
    .WIDTH(5), .TAPS(5'b10010), .LOCK_CNT(8), .LOSS_CNT(300), .ERR_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .err_clr(err_clr), .locked(locked_b), .err_pulse(err_pulse_b),
    .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: hist[k] is the bit loaded k valid cycles ago.
  typedef struct packed {
    logic [7:0] hist;
    logic       lk;
    int         match;
    int         miss;
    int         err;
    logic       pulse;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(input model_t m, input logic v,
                                        input logic b, input logic c,
                                        input int loss);
    logic pred, nz, inc, nb;
    pred = 1'b0;
    nz   = 1'b0;
    inc  = 1'b0;
    nb   = b;
    for (int k = 0; k < 5; k++) begin
      if (TB_TAPS[k]) pred = pred ^ m.hist[k];
      if (m.hist[k]) nz = 1'b1;
    end
    m.pulse = 1'b0;
    if (v) begin
      if (!m.lk) begin
        if ((b == pred) && nz) begin
          m.match = m.match + 1;
          if (m.match == TB_LOCK) begin
            m.lk    = 1'b1;
            m.match = 0;
          end
        end else begin
          m.match = 0;
        end
      end else begin
        nb = pred;
        if (b != pred) begin
          inc     = 1'b1;
          m.pulse = 1'b1;
          m.miss  = m.miss + 1;
          if (m.miss == loss) begin
            m.lk    = 1'b0;
            m.miss  = 0;
            m.match = 0;
          end
        end else begin
          m.miss = 0;
        end
      end
      m.hist = {m.hist[6:0], nb};
    end
    if (c) m.err = inc ? 1 : 0;
    else if (inc && (m.err < ERR_MAX)) m.err = m.err + 1;
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_locked",    32'(locked_a),    32'(ma.lk));
      check("a_err_pulse", 32'(err_pulse_a), 32'(ma.pulse));
      check("a_err_cnt",   32'(err_cnt_a),   32'(ma.err));
      check("b_locked",    32'(locked_b),    32'(mb.lk));
      check("b_err_pulse", 32'(err_pulse_b), 32'(mb.pulse));
      check("b_err_cnt",   32'(err_cnt_b),   32'(mb.err));
    end
  end

  // PRBS5 source, SEED=1; q[0] is the transmitted bit.
  logic [4:0] gen;

  task automatic next_gen(output logic b);
    b   = gen[0];
    gen = {gen[3:0], ^(gen & TB_TAPS)};
  endtask

  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    err_clr  = c;
    @(posedge clk);
    ma = model_step(ma, v, b, c, 4);
    mb = model_step(mb, v, b, c, 300);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic flip, input logic clr);
    logic b;
    next_gen(b);
    step(1'b1, b ^ flip, clr);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    err_clr  = 1'b0;
    ma       = '0;
    mb       = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_locked",  32'(locked_a | locked_b), 32'd0);
    check("rst_pulse",   32'(err_pulse_a | err_pulse_b), 32'd0);
    check("rst_err_cnt", 32'(err_cnt_a | err_cnt_b), 32'd0);
    rst = 1'b0;
    gen = 5'b00001;
  endtask

  // Clean valid bits until dut_a locks; n = bits used, or -1 if none.
  task automatic wait_lock(input int max_bits, output int n);
    n = -1;
    for (int i = 1; i <= max_bits; i++) begin
      send(1'b0, 1'b0);
      if (locked_a) begin
        n = i;
        break;
      end
    end
  endtask

  int   n_lock;
  int   n_valid;
  logic seq_bit;
  logic [9:0] seq10;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; err_clr = 1'b0;
    ma = '0; mb = '0; gen = 5'b00001;

    // Pin the source: first ten SEED=1 bits, hand-derived.
    for (int i = 0; i < 10; i++) begin
      next_gen(seq_bit);
      seq10[9-i] = seq_bit;
    end
    check("gen_first10", 32'(seq10), 32'(10'b1010111011));

    do_reset();
    chk_en = 1'b1;

    // Acquisition: match_cnt reaches 8 on the 9th bit.
    wait_lock(14, n_lock);
    check("lock_latency", n_lock, 9);
    repeat (200) send(1'b0, 1'b0);
    check("clean_err_cnt", 32'(err_cnt_a), 32'd0);

    // Single inverted bit.
    send(1'b1, 1'b0);
    check("single_pulse", 32'(err_pulse_a), 32'd1);
    check("single_cnt",   32'(err_cnt_a),   32'd1);
    check("single_lock",  32'(locked_a),    32'd1);
    send(1'b0, 1'b0);
    check("single_after", 32'(err_pulse_a), 32'd0);
    repeat (20) send(1'b0, 1'b0);

    // Four consecutive inverted bits drop dut_a out of lock.
    repeat (3) send(1'b1, 1'b0);
    check("burst_lock3", 32'(locked_a), 32'd1);
    send(1'b1, 1'b0);
    check("burst_unlock", 32'(locked_a),  32'd0);
    check("burst_cnt",    32'(err_cnt_a), 32'd5);
    check("burst_b_lock", 32'(locked_b),  32'd1);
    wait_lock(14, n_lock);
    check("relock", 32'((n_lock >= 1) && (n_lock <= 14)), 32'd1);
    repeat (50) send(1'b0, 1'b0);
    check("relock_cnt", 32'(err_cnt_a), 32'd5);

    // All-zero input must not lock; then a gappy clean stream.
    do_reset();
    repeat (60) step(1'b1, 1'b0, 1'b0);
    check("zeros_nolock", 32'(locked_a), 32'd0);
    n_lock  = -1;
    n_valid = 0;
    for (int i = 0; i < 40 && n_lock < 0; i++) begin
      if (i % 2 == 1) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        send(1'b0, 1'b0);
        n_valid = n_valid + 1;
        if (locked_a) n_lock = n_valid;
      end
    end
    check("gappy_lock", n_lock, 9);
    check("gappy_cnt", 32'(err_cnt_a), 32'd0);

    // Randomised traffic: gaps, sparse bit errors, occasional clears.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) != 0) begin
        send(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 49) == 0));
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    // Saturation: 300 errors, every other bit inverted.
    do_reset();
    wait_lock(14, n_lock);
    check("sat_lock", n_lock, 9);
    for (int i = 0; i < 600; i++) send(1'(i % 2 == 0), 1'b0);
    check("sat_a",      32'(err_cnt_a), 32'd255);
    check("sat_b",      32'(err_cnt_b), 32'd255);
    check("sat_b_lock", 32'(locked_b),  32'd1);
    send(1'b1, 1'b1);
    check("clr_with_err", 32'(err_cnt_b), 32'd1);
    send(1'b0, 1'b1);
    check("clr_alone", 32'(err_cnt_b), 32'd0);
    send(1'b0, 1'b0);
    check("pre_rst_lock", 32'(locked_a & locked_b), 32'd1);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("arst_locked", 32'(locked_a | locked_b), 32'd0);
    check("arst_pulse",  32'(err_pulse_a | err_pulse_b), 32'd0);
    ma = '0;
    mb = '0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    gen = 5'b00001;
    repeat (5) send(1'b0, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
